// File: rtl/frame_min_if.sv
// frame_min_if -- handshake/result bundle between a sample producer and
// frame_min_collector.
//   master : drives start, in_valid, in_num, out_ack; observes the rest
//   slave  : the collector; drives in_ready, busy, min_*, all_equal, out_valid
interface frame_min_if;
   logic       start;
   logic       in_valid;
   logic [3:0] in_num;
   logic       in_ready;
   logic       busy;
   logic [3:0] min_num;
   logic [3:0] min_index;
   logic [4:0] min_count;
   logic       all_equal;
   logic       out_valid;
   logic       out_ack;

   modport master (
      output start, in_valid, in_num, out_ack,
      input  in_ready, busy, min_num, min_index, min_count, all_equal, out_valid
   );

   modport slave (
      input  start, in_valid, in_num, out_ack,
      output in_ready, busy, min_num, min_index, min_count, all_equal, out_valid
   );
endinterface

// File: rtl/frame_min_collector.sv
// frame_min_collector -- collects a frame of WINDOW 4-bit samples and tracks
// the running minimum, the position of its first occurrence and how many
// samples equal it. The frame result is held on out_valid until out_ack.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high
//   bus  : frame_min_if.slave (start/in_valid/in_num/in_ready sample side,
//          min_num/min_index/min_count/all_equal/out_valid/out_ack result side)
module frame_min_collector #(
   parameter int WINDOW = 8
) (
   input  logic       clk,
   input  logic       rst,
   frame_min_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   localparam logic [3:0] LAST_POS = 4'(WINDOW - 1);
   localparam logic [4:0] FULL_CNT = 5'(WINDOW);

   state_t     state, state_nx;
   logic [3:0] pos;
   logic [3:0] min_num_q;
   logic [3:0] min_index_q;
   logic [4:0] min_count_q;
   logic       accept;
   logic       clr;

   assign accept = (state == COLLECT) && bus.in_valid;
   // Results are zero in IDLE and on the edge that leaves DONE, whether the
   // next stop is IDLE or a back-to-back COLLECT.
   assign clr    = (state == IDLE) || ((state == DONE) && bus.out_ack);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = COLLECT;
         COLLECT: if (accept && (pos == LAST_POS)) state_nx = DONE;
         DONE:    if (bus.out_ack) state_nx = bus.start ? COLLECT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pos         <= '0;
         min_num_q   <= '0;
         min_index_q <= '0;
         min_count_q <= '0;
      end else if (accept) begin
         pos <= pos + 4'd1;
         // Sample 0 always loads; a strictly smaller value restarts the count.
         if ((pos == 4'd0) || (bus.in_num < min_num_q)) begin
            min_num_q   <= bus.in_num;
            min_index_q <= pos;
            min_count_q <= 5'd1;
         end else if (bus.in_num == min_num_q) begin
            min_count_q <= min_count_q + 5'd1;
         end
      end
   end

   // in_ready/busy/out_valid/all_equal are decoded from registered state only.
   assign bus.in_ready  = (state == COLLECT);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.all_equal = (state == DONE) && (min_count_q == FULL_CNT);
   assign bus.min_num   = min_num_q;
   assign bus.min_index = min_index_q;
   assign bus.min_count = min_count_q;

endmodule

// File: tb/tb_frame_min_collector.sv
module tb_frame_min_collector;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   frm [16];

   frame_min_if bus();

   frame_min_collector #(.WINDOW(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: statistics of the first n samples of frm.
   function automatic void ref_stats(input int n, output int mn, output int ix, output int ct);
      mn = 0; ix = 0; ct = 0;
      if (n == 0) return;
      mn = 16;
      for (int i = 0; i < n; i++) if (frm[i] < mn) mn = frm[i];
      ix = -1;
      for (int i = 0; i < n; i++) begin
         if (frm[i] == mn) begin
            ct++;
            if (ix < 0) ix = i;
         end
      end
   endfunction

   task automatic check_stats(input string tag, input int n, input bit done);
      int mn, ix, ct;
      ref_stats(n, mn, ix, ct);
      chk({tag, "_min"}, bus.min_num, mn);
      chk({tag, "_idx"}, bus.min_index, ix);
      chk({tag, "_cnt"}, bus.min_count, ct);
      chk({tag, "_ovld"}, bus.out_valid, done);
      chk({tag, "_rdy"}, bus.in_ready, !done);
      chk({tag, "_aeq"}, bus.all_equal, done && (ct == W));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_rdy"}, bus.in_ready, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_ovld"}, bus.out_valid, 0);
      chk({tag, "_aeq"}, bus.all_equal, 0);
      chk({tag, "_min"}, bus.min_num, 0);
      chk({tag, "_idx"}, bus.min_index, 0);
      chk({tag, "_cnt"}, bus.min_count, 0);
   endtask

   task automatic begin_frame(input string tag);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk({tag, "_rdy"}, bus.in_ready, 1);
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_cnt0"}, bus.min_count, 0);
   endtask

   // gap: 0 full rate, 1 random stalls, 2 one stall before every sample
   task automatic run_frame(input string tag, input int n, input int gap);
      int g;
      for (int p = 0; p < n; p++) begin
         g = (gap == 2) ? 1 : (gap == 1) ? $urandom_range(0, 2) : 0;
         for (int k = 0; k < g; k++) begin
            bus.in_valid = 1'b0;
            bus.in_num   = 4'($urandom);
            bus.start    = 1'($urandom);
            step();
            check_stats({tag, "_gap"}, p, 0);
         end
         bus.start    = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_num   = 4'(frm[p]);
         step();
         check_stats(tag, p + 1, p == W - 1);
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic ack_to_idle(input string tag);
      bus.out_ack = 1'b1;
      step();
      bus.out_ack = 1'b0;
      check_idle(tag);
   endtask

   initial begin
      int mn, ix, ct, hold;
      rst = 1'b1;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_num = '0; bus.out_ack = 1'b0;

      // reset with random inputs
      repeat (2) begin
         bus.start    = 1'($urandom);
         bus.in_valid = 1'($urandom);
         bus.in_num   = 4'($urandom);
         bus.out_ack  = 1'($urandom);
         step();
      end
      check_idle("rst");
      rst = 1'b0; bus.in_valid = 1'b0; bus.out_ack = 1'b0;
      begin_frame("rst_start");

      // mixed frame, full rate
      frm[0:7] = '{9, 5, 7, 5, 12, 3, 3, 14};
      run_frame("mix", W, 0);
      chk("mix_min_c", bus.min_num, 3);
      chk("mix_idx_c", bus.min_index, 5);
      chk("mix_cnt_c", bus.min_count, 2);

      // output stall: in_valid with 0 and start must not disturb DONE
      bus.out_ack = 1'b0; bus.in_valid = 1'b1; bus.in_num = 4'd0; bus.start = 1'b1;
      repeat (10) begin
         step();
         check_stats("stall", W, 1);
      end
      bus.in_valid = 1'b0; bus.start = 1'b0;
      ack_to_idle("stall_ack");

      // all equal with toggled in_valid
      begin_frame("eq6");
      for (int i = 0; i < W; i++) frm[i] = 6;
      run_frame("eq6", W, 2);
      chk("eq6_aeq_c", bus.all_equal, 1);
      ack_to_idle("eq6_ack");

      begin_frame("eq15");
      for (int i = 0; i < W; i++) frm[i] = 15;
      run_frame("eq15", W, 0);
      chk("eq15_min_c", bus.min_num, 15);
      ack_to_idle("eq15_ack");

      begin_frame("z7");
      for (int i = 0; i < W - 1; i++) frm[i] = $urandom_range(1, 15);
      frm[W-1] = 0;
      run_frame("z7", W, 0);
      chk("z7_min_c", bus.min_num, 0);
      chk("z7_idx_c", bus.min_index, 7);
      ack_to_idle("z7_ack");

      // reset mid-frame
      begin_frame("mid");
      for (int i = 0; i < W; i++) frm[i] = $urandom_range(0, 15);
      run_frame("mid", 4, 0);
      rst = 1'b1; bus.in_valid = 1'b1; bus.in_num = 4'd1;
      step();
      rst = 1'b0; bus.in_valid = 1'b0;
      check_idle("mid_rst");
      begin_frame("post");
      frm[0:7] = '{8, 8, 8, 8, 8, 8, 8, 2};
      run_frame("post", W, 0);
      chk("post_min_c", bus.min_num, 2);
      chk("post_idx_c", bus.min_index, 7);
      chk("post_cnt_c", bus.min_count, 1);

      // back-to-back from DONE
      bus.out_ack = 1'b1; bus.start = 1'b1;
      step();
      bus.out_ack = 1'b0; bus.start = 1'b0;
      chk("b2b_rdy", bus.in_ready, 1);
      chk("b2b_ovld", bus.out_valid, 0);
      chk("b2b_min", bus.min_num, 0);
      chk("b2b_cnt", bus.min_count, 0);
      for (int i = 0; i < W; i++) frm[i] = $urandom_range(4, 9);
      run_frame("b2b", W, 1);

      // randomized frames, random gaps, hold times and exits
      for (int f = 0; f < 30; f++) begin
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            bus.start = 1'($urandom); bus.in_valid = 1'($urandom); bus.in_num = 4'($urandom);
            step();
            check_stats("rnd_hold", W, 1);
         end
         bus.in_valid = 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            bus.out_ack = 1'b1; bus.start = 1'b1;
            step();
            bus.out_ack = 1'b0; bus.start = 1'b0;
            check_stats("rnd_b2b", 0, 0);
         end else begin
            bus.start = 1'b0;
            ack_to_idle("rnd_ack");
            begin_frame("rnd_go");
         end
         for (int i = 0; i < W; i++)
            frm[i] = (f % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(3, 5);
         run_frame("rnd", W, $urandom_range(0, 1));
         ref_stats(W, mn, ix, ct);
         chk("rnd_final_cnt", bus.min_count, ct);
      end
      ack_to_idle("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frame_min_collector.md
# frame_min_collector

Upstream stage for the small-number / seven-segment display path. It accepts a frame of WINDOW 4-bit samples over a valid/ready handshake and tracks the running minimum, its first position and its multiplicity. It then presents the frame result on a held output handshake. `min_num` drives the existing seven-segment driver directly, and `all_equal` plays the role of the comparator's `equal` flag.

## Interface
- WINDOW, 8, samples per frame; legal range 2..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  begin a frame; honoured only in IDLE, or in DONE together with `out_ack`.
- in_valid  in  1  `in_num` is valid this cycle.
- in_num  in  4  unsigned sample.
- in_ready  out  1  block accepts a sample this cycle.
- busy  out  1  high in COLLECT and DONE.
- min_num  out  4  running minimum (COLLECT) or final minimum (DONE).
- min_index  out  4  0-based position of the first occurrence of `min_num` in the frame.
- min_count  out  5  number of samples equal to `min_num` so far.
- all_equal  out  1  high in DONE when `min_count == WINDOW`.
- out_valid  out  1  frame result valid; held until acknowledged.
- out_ack  in  1  consumer has taken the result.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - `start` → COLLECT.
  - Sample counter clears.
  - `min_num`, `min_index`, `min_count` clear to 0.
- COLLECT:
  - A sample is accepted on an edge where `in_valid & in_ready`; `in_ready` = (state == COLLECT).
  - Sample 0 loads: `min_num` ← `in_num`, `min_index` ← 0, `min_count` ← 1.
  - Later sample `s` at position p:
    - s < `min_num`: `min_num` ← s, `min_index` ← p, `min_count` ← 1.
    - s == `min_num`: `min_count` += 1; `min_index` unchanged (first occurrence wins).
    - s > `min_num`: no change.
  - Comparison is unsigned 4-bit.
  - `min_count` cannot exceed 16, so it needs no saturation.
  - On acceptance of sample WINDOW-1 → DONE.
  - `start` is ignored in COLLECT.
- DONE:
  - Outputs are frozen and `out_valid` = 1.
  - `in_valid` is ignored.
  - `out_ack` alone → IDLE.
  - `out_ack & start` → COLLECT directly for a back-to-back frame. Results clear on that edge.
  - `start` without `out_ack` is ignored.
- Outputs that are not `out_valid` (`min_num`, `min_index`, `min_count`) stay observable during COLLECT for live display.
- `all_equal` is 0 outside DONE.

## Timing
- Reset values, all outputs:
  - `in_ready`, `busy`, `out_valid`, `all_equal` = 0.
  - `min_num`, `min_index`, `min_count` = 0.
  - State = IDLE.
- `rst` has priority over every other input in every state:
  - A frame in progress is discarded.
  - A pending `out_valid` drops on the next edge.
- `in_ready` rises in the cycle after the edge where `start` was sampled.
- The first sample can be accepted on the following edge.
- Running-minimum registers update on the same edge that accepts a sample; the new values are visible the next cycle.
- Full-rate input gives WINDOW consecutive accepting edges.
- Gaps in `in_valid` stall without side effects.
- `out_valid` and `all_equal` are high in the cycle after the edge that accepts the last sample; `in_ready` is low in that same cycle.
- Latency: 1 cycle from the last-sample acceptance edge to result valid.
- `out_valid` is held for any number of cycles without `out_ack`.
- `out_ack` is sampled only while `out_valid` = 1; when high on an edge, `out_valid` is 0 the next cycle.
- All outputs are registered; there are no combinational input-to-output paths except `in_ready` (decoded from state only).

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0, `in_ready` = 0; `start` on the next cycle → `in_ready` = 1 the following cycle.
- **Mixed frame (WINDOW = 8):** 9, 5, 7, 5, 12, 3, 3, 14 at full rate → `out_valid` 1 cycle after the 8th accept; `min_num` = 3, `min_index` = 5, `min_count` = 2, `all_equal` = 0. During the frame, `min_num` reads 9, 5, 5, 5, 5, 3, 3, 3.
- **All-equal frame:** eight samples of 6 with `in_valid` toggled 1/0 → `min_num` = 6, `min_index` = 0, `min_count` = 8, `all_equal` = 1. Extreme values: all 15 → `min_num` = 15; frame containing one 0 at p = 7 → `min_num` = 0, `min_index` = 7.
- **Output stall:**
  - Withhold `out_ack` for 10 cycles while driving `in_valid` = 1 with value 0 → results unchanged, `in_ready` = 0, `start` ignored.
  - `out_ack` → IDLE next cycle, outputs 0.
- **Reset mid-frame:** `rst` after 4 of 8 samples → IDLE, outputs 0. A new frame 8, 8, 8, 8, 8, 8, 8, 2 → `min_num` = 2, `min_index` = 7, `min_count` = 1, with no residue from the aborted frame.
- **Back-to-back:** `out_ack` and `start` on the same edge in DONE → COLLECT next cycle with `out_valid` = 0 and results cleared; the second frame's results are independent of the first.
